// File: rtl/avr_dw_down_if.sv
// ---------------------------------------------------------------------------
// avr_dw_down_if
// Handshake bundle for the AVR data-width downsizer.
//   m_data/m_cnt/m_valid/m_ready : wide-beat side (upstream -> block)
//   s_data/s_valid/s_ready       : narrow-beat side (block -> downstream)
//   s_last                       : final narrow slice marker, present only
//                                  when AVR_DW_DOWN_LAST_EN is defined
// Modports:
//   slave  : the downsizer's view
//   master : the environment's view (drives upstream beats, downstream ready)
// ---------------------------------------------------------------------------
interface avr_dw_down_if #(
   parameter int DW_OUT = 64,
   parameter int RATIO  = 4,
   parameter int CW     = 2
);
   logic [DW_OUT*RATIO-1:0] m_data;
   logic [CW-1:0]           m_cnt;
   logic                    m_valid;
   logic                    m_ready;
   logic [DW_OUT-1:0]       s_data;
   logic                    s_valid;
   logic                    s_ready;
`ifdef AVR_DW_DOWN_LAST_EN
   logic                    s_last;

   modport slave  (input  m_data, m_cnt, m_valid, s_ready,
                   output m_ready, s_data, s_valid, s_last);
   modport master (output m_data, m_cnt, m_valid, s_ready,
                   input  m_ready, s_data, s_valid, s_last);
`else
   modport slave  (input  m_data, m_cnt, m_valid, s_ready,
                   output m_ready, s_data, s_valid);
   modport master (output m_data, m_cnt, m_valid, s_ready,
                   input  m_ready, s_data, s_valid);
`endif
endinterface

// File: rtl/avr_dw_down.sv
// ---------------------------------------------------------------------------
// avr_dw_down
// AVR-handshake data-width downsizer. Accepts one wide beat of RATIO*DW_OUT
// bits and emits m_cnt+1 (clamped to RATIO) narrow beats of DW_OUT bits,
// least-significant slice first. Back-to-back wide beats are accepted on the
// cycle the previous beat's last slice transfers, so there is no bubble.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : avr_dw_down_if.slave
//            m_data/m_cnt/m_valid in, m_ready out   (wide side)
//            s_data/s_valid out, s_ready in         (narrow side)
//            s_last out (only with AVR_DW_DOWN_LAST_EN)
//
// Optional feature macro: AVR_DW_DOWN_LAST_EN adds s_last, high alongside
// s_valid on the final narrow slice of each wide beat.
//
// The only combinational path to an output is s_ready -> m_ready; s_data and
// s_valid come straight from registers.
// ---------------------------------------------------------------------------
module avr_dw_down #(
   parameter int DW_OUT = 64,
   parameter int RATIO  = 4,
   parameter int CW     = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   avr_dw_down_if.slave   bus
);
   localparam int DW_IN = DW_OUT * RATIO;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t            r_state;
   logic [DW_IN-1:0]  r_hold;
   logic [CW-1:0]     r_idx;
   logic [CW-1:0]     r_lst;
   logic [DW_OUT-1:0] r_sdata;
   logic              r_svalid;

   logic              w_at_last;
   logic              w_m_ready;
   logic              w_m_xfer;
   logic              w_s_xfer;
   logic [CW-1:0]     w_idx_nxt;
   logic [CW-1:0]     w_lst_in;

   // Mux one DW_OUT slice out of a wide word; indices at or above RATIO
   // select nothing (they cannot occur since lst is clamped).
   function automatic logic [DW_OUT-1:0] f_slice(input logic [DW_IN-1:0] w,
                                                 input logic [CW-1:0]    k);
      logic [DW_OUT-1:0] r;
      r = '0;
      for (int i = 0; i < RATIO; i++)
         if (int'(k) == i) r = w[i*DW_OUT +: DW_OUT];
      return r;
   endfunction

   // Out-of-range counts clamp to the last slice; for RATIO=1 this forces 0.
   function automatic logic [CW-1:0] f_clamp(input logic [CW-1:0] c);
      return (int'(c) > RATIO - 1) ? CW'(RATIO - 1) : c;
   endfunction

   assign w_at_last = (r_idx == r_lst);
   assign w_idx_nxt = r_idx + CW'(1);
   assign w_lst_in  = f_clamp(bus.m_cnt);

   // Ready in IDLE, or when the last slice is leaving this cycle.
   assign w_m_ready = (r_state == S_IDLE) | (bus.s_ready & w_at_last);
   assign w_m_xfer  = bus.m_valid & w_m_ready;
   assign w_s_xfer  = r_svalid & bus.s_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_hold   <= '0;
         r_idx    <= '0;
         r_lst    <= '0;
         r_sdata  <= '0;
         r_svalid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_m_xfer) begin
                  r_hold   <= bus.m_data;
                  r_lst    <= w_lst_in;
                  r_idx    <= '0;
                  r_sdata  <= bus.m_data[DW_OUT-1:0];
                  r_svalid <= 1'b1;
                  r_state  <= S_SEND;
               end
            end
            S_SEND: begin
               if (w_s_xfer) begin
                  if (!w_at_last) begin
                     r_idx   <= w_idx_nxt;
                     r_sdata <= f_slice(r_hold, w_idx_nxt);
                  end else if (bus.m_valid) begin
                     // Last slice leaving and a new wide beat waiting:
                     // reload in the same cycle for zero-bubble streaming.
                     r_hold   <= bus.m_data;
                     r_lst    <= w_lst_in;
                     r_idx    <= '0;
                     r_sdata  <= bus.m_data[DW_OUT-1:0];
                  end else begin
                     r_svalid <= 1'b0;
                     r_state  <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_svalid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.m_ready = w_m_ready;
   assign bus.s_data  = r_sdata;
   assign bus.s_valid = r_svalid;

`ifdef AVR_DW_DOWN_LAST_EN
   // idx, lst and s_valid are all registers, so this changes only on the
   // same edges as s_data and resets to 0 with s_valid.
   assign bus.s_last = r_svalid & w_at_last;
`endif

endmodule
